hcsr04_ranger: RTL and testbench

Ultrasonic ranging front-end for the radar: periodically fires an HC-SR04 trigger pulse, times the returned echo, and converts its width to a distance in centimetres. Drives the sensor's trig pin and presents a 10-bit distance word plus status to the Avalon slave that exposes `uart_out_readdata`, `uart_out_echo` and `uart_out_trig` in `Computer_System`. The block sits directly upstream of that bus-visible register.

---
 rtl/ranger_pkg.sv | 29 ++
 rtl/echo_sync.sv | 30 +++
 rtl/hcsr04_ranger.sv | 141 ++++++++++++++
 tb/tb_hcsr04_ranger.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// ranger_pkg: shared state encoding and cycle-count derivations for the HC-SR04 ranger
package ranger_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  function automatic int us_to_cyc(input int us, input int hz);
    return int'((longint'(us) * longint'(hz)) / 64'sd1_000_000);
  endfunction

  function automatic int ms_to_cyc(input int ms, input int hz);
    return int'((longint'(ms) * longint'(hz)) / 64'sd1_000);
  endfunction

  // Sound round trip takes 58 us per centimetre of range
  function automatic int cm_to_cyc(input int hz);
    return us_to_cyc(58, hz);
  endfunction

  function automatic int sat_val(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: 2-FF synchronizer for an asynchronous input with registered rise/fall pulses
module echo_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sh;
  logic       r_rise;
  logic       r_fall;

  // r_sh[1:0] is the metastability chain; r_sh[2] is the previous synced level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh   <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sh   <= {r_sh[1:0], i_async};
      r_rise <= r_sh[1] & ~r_sh[2];
      r_fall <= ~r_sh[1] & r_sh[2];
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: periodic HC-SR04 trigger, echo timing and centimetre conversion
module hcsr04_ranger
  import ranger_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25_000,
  parameter int DIST_W     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] readdata,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int TRIG_CYC = us_to_cyc(TRIG_US, CLK_HZ);
  localparam int CM_CYC   = cm_to_cyc(CLK_HZ);
  localparam int TMO_CYC  = us_to_cyc(TIMEOUT_US, CLK_HZ);
  localparam int PER_CYC  = ms_to_cyc(PERIOD_MS, CLK_HZ);
  localparam int PER_W    = $clog2(PER_CYC + 1);
  localparam int SUB_W    = $clog2(CM_CYC);
  localparam logic [DIST_W-1:0] SAT = DIST_W'(sat_val(DIST_W));

  state_t            r_state;
  state_t            w_next;
  logic [PER_W-1:0]  r_per;
  logic [SUB_W-1:0]  r_sub;
  logic [DIST_W-1:0] r_cm;
  logic [DIST_W-1:0] r_data;
  logic              r_valid;
  logic              r_tmo;
  logic              r_trig;
  logic              w_rise;
  logic              w_fall;
  logic              w_tmo_hit;
  logic              w_wrap;
  logic              w_done;
  logic              w_to;
  logic [DIST_W-1:0] w_cm_nxt;

  echo_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (echo),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_tmo_hit = r_per >= PER_W'(TMO_CYC);
  assign w_wrap    = r_sub == SUB_W'(CM_CYC - 1);
  assign w_cm_nxt  = (w_wrap && r_cm != SAT) ? r_cm + DIST_W'(1) : r_cm;

  // Next-state logic; timeout wins over a coincident echo edge so MEASURE can never hang
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      S_IDLE:      if (enable) w_next = S_TRIG;
      S_TRIG:      if (r_per == PER_W'(TRIG_CYC - 1)) w_next = S_WAIT_RISE;
      S_WAIT_RISE: if (w_tmo_hit) begin
                     w_to   = 1'b1;
                     w_next = S_HOLDOFF;
                   end else if (w_rise) w_next = S_MEASURE;
      S_MEASURE:   if (w_tmo_hit) begin
                     w_to   = 1'b1;
                     w_next = S_HOLDOFF;
                   end else if (w_fall) begin
                     w_done = 1'b1;
                     w_next = S_HOLDOFF;
                   end
      // Leaving one count early: the IDLE cycle makes trigger spacing exactly PER_CYC
      S_HOLDOFF:   if (r_per >= PER_W'(PER_CYC - 2)) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Period counter: held at zero in IDLE so it starts from zero on the first TRIG cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_per <= '0;
    else if (r_state == S_IDLE)  r_per <= '0;
    else                         r_per <= r_per + PER_W'(1);
  end

  // Echo width counters: cleared while waiting for the rising edge, saturating cm count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sub <= '0;
      r_cm  <= '0;
    end else if (r_state == S_WAIT_RISE) begin
      r_sub <= '0;
      r_cm  <= '0;
    end else if (r_state == S_MEASURE) begin
      r_sub <= w_wrap ? '0 : r_sub + SUB_W'(1);
      r_cm  <= w_cm_nxt;
    end
  end

  // Result latch: the falling-edge cycle itself is counted, giving floor(width / CM_CYC)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_tmo   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_done | w_to;
      if (w_done) begin
        r_data <= w_cm_nxt;
        r_tmo  <= 1'b0;
      end else if (w_to) begin
        r_data <= SAT;
        r_tmo  <= 1'b1;
      end
    end
  end

  // Registered trigger avoids decode glitches on the sensor pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_trig <= 1'b0;
    else          r_trig <= w_next == S_TRIG;
  end

  assign trig     = r_trig;
  assign readdata = r_data;
  assign valid    = r_valid;
  assign timeout  = r_tmo;
  assign busy     = r_state != S_IDLE;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: randomized scoreboard bench for the ultrasonic ranger
module tb_hcsr04_ranger;

  localparam int CLK_HZ     = 500_000;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 3;
  localparam int TIMEOUT_US = 2000;
  localparam int DIST_W     = 5;

  localparam int TRIG = int'(longint'(TRIG_US) * CLK_HZ / 1_000_000);
  localparam int CM   = int'(longint'(58) * CLK_HZ / 1_000_000);
  localparam int TMO  = int'(longint'(TIMEOUT_US) * CLK_HZ / 1_000_000);
  localparam int PER  = int'(longint'(PERIOD_MS) * CLK_HZ / 1_000);
  localparam int SAT  = (1 << DIST_W) - 1;

  typedef struct {
    int data;
    bit tmo;
    int at;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              echo = 1'b0;
  logic              trig;
  logic [DIST_W-1:0] readdata;
  logic              valid;
  logic              timeout;
  logic              busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   prev_e = -1;
  int   last_data = 0;
  bit   last_tmo = 1'b0;
  bit   have_last = 1'b0;

  hcsr04_ranger #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .PERIOD_MS  (PERIOD_MS),
    .TIMEOUT_US (TIMEOUT_US),
    .DIST_W     (DIST_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .echo     (echo),
    .trig     (trig),
    .readdata (readdata),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse consumes one expected result
  initial begin : monitor
    bit   pv = 1'b0;
    exp_t x;
    forever begin
      @(negedge clk);
      if (reset_n && valid) begin
        chk("valid_single_cycle", int'(pv), 0);
        chk("pending_results", q.size(), 1);
        if (q.size() > 0) begin
          x = q.pop_front();
          chk("readdata", int'(readdata), x.data);
          chk("timeout", int'(timeout), int'(x.tmo));
          chk("valid_cycle", cyc, x.at);
        end
      end
      pv = reset_n && valid;
    end
  end

  task automatic wait_trig(output int e);
    int n = 0;
    while (trig !== 1'b1 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    chk("trig_rise_seen", int'(trig === 1'b1), 1);
    e = cyc;
    if (prev_e >= 0) chk("trig_period", e - prev_e, PER);
    prev_e = e;
    if (have_last) begin
      chk("held_readdata", int'(readdata), last_data);
      chk("held_timeout", int'(timeout), int'(last_tmo));
    end
    n = 0;
    while (trig === 1'b1 && n < 2 * TRIG) begin
      @(negedge clk);
      n++;
    end
    chk("trig_width", n, TRIG);
  endtask

  // One full measurement; w == 0 means no echo edge arrives in the window
  task automatic measure(input int w, input int d, input bit stuck, input bit drop_en);
    int   e;
    int   n = 0;
    exp_t x;
    if (stuck) echo = 1'b1;
    wait_trig(e);
    if (drop_en) enable = 1'b0;
    if (w == 0) begin
      x.data = SAT;
      x.tmo  = 1'b1;
      x.at   = e + TMO + 1;
    end else begin
      repeat (d) @(negedge clk);
      echo = 1'b1;
      repeat (w) @(negedge clk);
      echo = 1'b0;
      x.data = (w / CM > SAT) ? SAT : w / CM;
      x.tmo  = 1'b0;
      x.at   = cyc + 4;
    end
    q.push_back(x);
    while (q.size() != 0 && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    chk("result_delivered", q.size(), 0);
    q.delete();
    if (stuck) echo = 1'b0;
    last_data = x.data;
    last_tmo  = x.tmo;
    have_last = 1'b1;
  endtask

  initial begin : stimulus
    int e;
    int w;
    int d;
    int nt;
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(trig), 0);
    chk("rst_readdata", int'(readdata), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    enable  = 1'b1;

    measure(10 * CM, 100, 1'b0, 1'b0);
    measure(CM - 1, 50, 1'b0, 1'b0);
    measure(CM, 50, 1'b0, 1'b0);
    measure(0, 0, 1'b0, 1'b0);
    measure(0, 0, 1'b1, 1'b0);
    measure(20 * CM, 200, 1'b0, 1'b0);
    measure(950, 5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      w = ($urandom % 4 == 0) ? 0 : int'($urandom_range(930, 1));
      d = int'($urandom_range(960 - w, 1));
      measure(w, d, 1'b0, 1'b0);
    end

    measure(12 * CM + 2, 30, 1'b0, 1'b1);
    nt = 0;
    repeat (2 * PER) begin
      @(negedge clk);
      if (trig === 1'b1) nt++;
    end
    chk("no_trig_disabled", nt, 0);
    chk("idle_busy", int'(busy), 0);

    enable = 1'b1;
    prev_e = -1;
    wait_trig(e);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    chk("busy_measure", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_trig", int'(trig), 0);
    chk("mid_rst_readdata", int'(readdata), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    chk("mid_rst_busy", int'(busy), 0);
    echo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 chk("trig_before_edge", int'(trig), 0);
    @(posedge clk);
    #1 chk("trig_after_reset", int'(trig), 1);
    prev_e    = -1;
    last_data = 0;
    last_tmo  = 1'b0;
    @(negedge clk);
    measure(5 * CM, 40, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
